countdown_timer: RTL and testbench

// Game-round countdown timer feeding the two-digit 7-segment decoder. Holds a
// 0-99 count, decrements once per CLOCKS_PER_TICK clock cycles while running,
// and reports expiry. hex_out connects directly to the decoder's 7-bit hex

---
 rtl/countdown_timer.sv | 114 +++++++++++
 tb/tb_countdown_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Two-digit game-round countdown timer. Counts a 0-99 value down once per
// CLOCKS_PER_TICK cycles while running and pulses expired when it reaches 0.
// hex_out drives the 7-segment decoder directly; 7'd127 blanks it.
module countdown_timer #(
    parameter int unsigned CLOCKS_PER_TICK = 50000000,
    parameter bit          BLANK_WHEN_IDLE = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] load_value,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] hex_out,
    output logic       running,
    output logic       expired
);

    localparam int unsigned PresW = $clog2(CLOCKS_PER_TICK);
    localparam logic [PresW-1:0] TickLast = PresW'(CLOCKS_PER_TICK - 1);
    localparam logic [6:0] MaxCount = 7'd99;
    localparam logic [6:0] BlankCode = 7'd127;

    typedef enum logic [1:0] {
        StIdle,
        StRunning,
        StPaused,
        StExpired
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       count_q, count_d;
    logic [PresW-1:0] presc_q, presc_d;
    logic             expired_q, expired_d;

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 7'd0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    // Next-state logic; load overrides everything, then pause, then start.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        expired_d = 1'b0;

        if (load) begin
            // Any tick coinciding with load is dropped.
            count_d = (load_value > MaxCount) ? MaxCount : load_value;
            presc_d = '0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (count_q != 7'd0)) begin
                        state_d = StRunning;
                        presc_d = '0;
                    end
                end
                StRunning: begin
                    if (pause) begin
                        // Freeze without applying a tick due this cycle.
                        state_d = StPaused;
                    end else if (presc_q == TickLast) begin
                        presc_d = '0;
                        if (count_q != 7'd0) begin
                            count_d = count_q - 7'd1;
                        end
                        if (count_q <= 7'd1) begin
                            state_d   = StExpired;
                            expired_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PresW'(1);
                    end
                end
                StPaused: begin
                    // Prescaler is kept so the partial tick survives a pause.
                    if (start && !pause) begin
                        state_d = StRunning;
                    end
                end
                StExpired: begin
                    count_d = 7'd0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        hex_out = count_q;
        if ((state_q == StIdle) && BLANK_WHEN_IDLE) begin
            hex_out = BlankCode;
        end
        running = (state_q == StRunning);
        expired = expired_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with CLOCKS_PER_TICK=4, BLANK_WHEN_IDLE=1.
// A behavioural model predicts the outputs every cycle; directed literal
// checks pin the model against hand-computed values.
module tb_countdown_timer;

    localparam int Cpt = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_value = 7'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] hex_out;
    logic       running;
    logic       expired;

    int total = 0;
    int bad = 0;

    countdown_timer #(
        .CLOCKS_PER_TICK(Cpt),
        .BLANK_WHEN_IDLE(1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .hex_out   (hex_out),
        .running   (running),
        .expired   (expired)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural model: a count, cycles since last tick and a mode flag set.
    int m_count = 0;
    int m_phase = 0;
    bit m_run = 0;
    bit m_paused = 0;
    bit m_done = 0;
    bit m_exp = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_count = 0; m_phase = 0; m_run = 0; m_paused = 0; m_done = 0; m_exp = 0;
        end else begin
            m_exp = 0;
            if (load) begin
                m_count = (int'(load_value) > 99) ? 99 : int'(load_value);
                m_phase = 0; m_run = 0; m_paused = 0; m_done = 0;
            end else if (m_run) begin
                if (pause) begin
                    m_run = 0;
                    m_paused = 1;
                end else begin
                    m_phase++;
                    if (m_phase == Cpt) begin
                        m_phase = 0;
                        m_count--;
                        if (m_count == 0) begin
                            m_run = 0; m_done = 1; m_exp = 1;
                        end
                    end
                end
            end else if (m_paused) begin
                if (start && !pause) begin
                    m_paused = 0;
                    m_run = 1;
                end
            end else if (!m_done) begin
                if (start && m_count > 0) begin
                    m_run = 1;
                    m_phase = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("model_hex", int'(hex_out),
                  (!m_run && !m_paused && !m_done) ? 127 : m_count);
            check("model_running", int'(running), int'(m_run));
            check("model_expired", int'(expired), int'(m_exp));
            check("hex_legal", int'((hex_out <= 7'd99) || (hex_out == 7'd127)), 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input int v);
        load_value = 7'(v);
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
    endtask

    initial begin
        // 1: reset mid-cycle, before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("t1_hex", int'(hex_out), 127);
        check("t1_running", int'(running), 0);
        check("t1_expired", int'(expired), 0);
        step(2);
        reset = 1'b0;
        step(1);

        // 2: load 3, run to expiry, start ignored while expired.
        do_load(3);
        do_start();
        check("t2_run", int'(running), 1);
        step(3);
        check("t2_k3", int'(hex_out), 3);
        step(1);
        check("t2_k4", int'(hex_out), 2);
        step(4);
        check("t2_k8", int'(hex_out), 1);
        step(4);
        check("t2_k12", int'(hex_out), 0);
        check("t2_exp", int'(expired), 1);
        step(1);
        check("t2_exp_off", int'(expired), 0);
        do_start();
        step(19);
        check("t2_hold", int'(hex_out), 0);
        check("t2_norun", int'(running), 0);

        // 3: pause with count=4, prescaler=2, then resume.
        do_load(5);
        do_start();
        step(6);
        do_pause();
        check("t3_paused", int'(hex_out), 4);
        check("t3_norun", int'(running), 0);
        step(10);
        check("t3_hold", int'(hex_out), 4);
        do_start();
        check("t3_resume", int'(running), 1);
        step(1);
        check("t3_r1", int'(hex_out), 4);
        step(1);
        check("t3_r2", int'(hex_out), 3);

        // 4: saturation and start ignored at zero.
        do_load(120);
        check("t4_blank", int'(hex_out), 127);
        do_start();
        check("t4_sat", int'(hex_out), 99);
        do_load(0);
        do_start();
        check("t4_zero_run", int'(running), 0);
        check("t4_zero_hex", int'(hex_out), 127);

        // 5: load on a tick edge, then start+pause together.
        do_load(5);
        do_start();
        step(3);
        do_load(9);
        check("t5_idle", int'(hex_out), 127);
        check("t5_norun", int'(running), 0);
        check("t5_noexp", int'(expired), 0);
        do_start();
        check("t5_count", int'(hex_out), 9);
        start = 1'b1;
        pause = 1'b1;
        step(1);
        check("t5_sp_run", int'(running), 0);
        check("t5_sp_hex", int'(hex_out), 9);
        step(1);
        start = 1'b0;
        pause = 1'b0;
        check("t5_sp_stay", int'(running), 0);
        step(4);
        check("t5_frozen", int'(hex_out), 9);

        // 6: reset while running at count=2.
        do_load(3);
        do_start();
        step(4);
        check("t6_pre", int'(hex_out), 2);
        #2 reset = 1'b1;
        #1;
        check("t6_hex", int'(hex_out), 127);
        check("t6_running", int'(running), 0);
        step(2);
        reset = 1'b0;
        step(10);
        check("t6_noexp", int'(expired), 0);
        do_start();
        check("t6_idle", int'(running), 0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
